nv_ram_rwsp_param: RTL and testbench

Parametrised 1R1W two-port RAM model and the successor to the fixed-size rwsp models: one write port, one read port with a read-address register stage and an output register stage, both driven by the same clock. It adds segmented write masking, a selectable read-during-write policy, output-valid tracking, collision reporting and out-of-range address handling. It is the drop-in target for the NVDLA buffer and FIFO RAM wrappers in the FPGA model flow.

---
 rtl/nv_ram_rwsp_param.sv | 135 +++++++++++++
 tb/tb_nv_ram_rwsp_param.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/nv_ram_rwsp_param.sv
// rtl/nv_ram_rwsp_param.sv - parametrised 1R1W RAM with registered read path, masking and collision tracking
module nv_ram_rwsp_param #(
  parameter int WIDTH    = 128,
  parameter int DEPTH    = 64,
  parameter int AW       = 6,
  parameter int MASK_W   = 1,
  parameter int RDW_MODE = 0,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [AW-1:0]     ra,
  input  logic              re,
  input  logic              ore,
  output logic [WIDTH-1:0]  dout,
  output logic              dout_vld,
  output logic              dout_collide,
  input  logic [AW-1:0]     wa,
  input  logic              we,
  input  logic [MASK_W-1:0] wmask,
  input  logic [WIDTH-1:0]  di,
  output logic [CNT_W-1:0]  collide_cnt,
  input  logic              collide_cnt_clr,
  input  logic [31:0]       pwrbus_ram_pd
);

  localparam int SEG_W = WIDTH / MASK_W;
  localparam logic [AW:0] DEPTH_A = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    ra_d_q, ra_d_d;
  logic             s1_vld_q, s1_vld_d;
  logic             s1_col_q, s1_col_d;
  logic [WIDTH-1:0] rd_hold_q, rd_hold_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_vld_q, dout_vld_d;
  logic             dout_col_q, dout_col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             wa_ok, ra_ok, ra_d_ok, wr_en, col_now;
  logic [WIDTH-1:0] ra_word, ra_d_word, s1_data;

  // The power-down bus is accepted for wrapper compatibility only.
  logic unused_pd;
  assign unused_pd = ^pwrbus_ram_pd;

  // Address range qualification and collision detection for the current cycle.
  always_comb begin
    wa_ok   = ({1'b0, wa} < DEPTH_A);
    ra_ok   = ({1'b0, ra} < DEPTH_A);
    ra_d_ok = ({1'b0, ra_d_q} < DEPTH_A);
    wr_en   = rstn & we & wa_ok;
    col_now = re & we & (ra == wa) & ra_ok;
  end

  // Array reads: pre-write word at ra, live word at the registered address; out-of-range gives zero.
  always_comb begin
    ra_word   = '0;
    ra_d_word = '0;
    if (ra_ok)   ra_word   = mem[ra];
    if (ra_d_ok) ra_d_word = mem[ra_d_q];
    if (RDW_MODE == 1) s1_data = ra_d_ok ? rd_hold_q : '0;
    else               s1_data = ra_d_word;
  end

  // Segmented write; unmasked segments and out-of-range writes leave the array untouched.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < MASK_W; k++) begin
        if (wmask[k]) mem[wa][k*SEG_W +: SEG_W] <= di[k*SEG_W +: SEG_W];
      end
    end
  end

  // Next state for the two read stages and the saturating collision counter.
  always_comb begin
    ra_d_d     = ra_d_q;
    rd_hold_d  = rd_hold_q;
    s1_vld_d   = s1_vld_q;
    s1_col_d   = s1_col_q;
    dout_d     = dout_q;
    dout_vld_d = dout_vld_q;
    dout_col_d = dout_col_q;
    cnt_d      = cnt_q;

    if (re) begin
      ra_d_d    = ra;
      rd_hold_d = ra_word;
      s1_vld_d  = 1'b1;
      s1_col_d  = col_now;
    end else if (ore) begin
      s1_vld_d  = 1'b0;
    end

    // Stage 2 takes the stage-1 view before stage 1 reloads, so re+ore streams.
    if (ore) begin
      dout_d     = s1_data;
      dout_vld_d = s1_vld_q;
      dout_col_d = s1_col_q & s1_vld_q;
    end

    if (collide_cnt_clr)                cnt_d = '0;
    else if (col_now && (cnt_q != '1))  cnt_d = cnt_q + CNT_W'(1);
  end

  // State registers; reset also discards any in-flight read.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ra_d_q     <= '0;
      rd_hold_q  <= '0;
      s1_vld_q   <= 1'b0;
      s1_col_q   <= 1'b0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      dout_col_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      ra_d_q     <= ra_d_d;
      rd_hold_q  <= rd_hold_d;
      s1_vld_q   <= s1_vld_d;
      s1_col_q   <= s1_col_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      dout_col_q <= dout_col_d;
      cnt_q      <= cnt_d;
    end
  end

  assign dout         = dout_q;
  assign dout_vld     = dout_vld_q;
  assign dout_collide = dout_col_q;
  assign collide_cnt  = cnt_q;

endmodule

// File: tb/tb_nv_ram_rwsp_param.sv
// tb/tb_nv_ram_rwsp_param.sv - self-checking bench for nv_ram_rwsp_param in both read-during-write modes
module tb_nv_ram_rwsp_param;

  localparam int DEPTH = 48;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [5:0]  ra = '0, wa = '0;
  logic        re = 1'b0, ore = 1'b0, we = 1'b0, clr = 1'b0;
  logic [3:0]  wmask = '0;
  logic [31:0] di = '0;
  logic [31:0] pwr = '0;

  logic [31:0] dout0, dout1;
  logic        vld0, vld1, dc0, dc1;
  logic [1:0]  cnt0, cnt1;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mm [DEPTH];
  int          cnt_m = 0;

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic        col;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  nv_ram_rwsp_param #(.WIDTH(32), .DEPTH(48), .AW(6), .MASK_W(4), .RDW_MODE(0), .CNT_W(2)) dut0 (
    .clk(clk), .rstn(rstn), .ra(ra), .re(re), .ore(ore), .dout(dout0), .dout_vld(vld0),
    .dout_collide(dc0), .wa(wa), .we(we), .wmask(wmask), .di(di), .collide_cnt(cnt0),
    .collide_cnt_clr(clr), .pwrbus_ram_pd(pwr));

  nv_ram_rwsp_param #(.WIDTH(32), .DEPTH(48), .AW(6), .MASK_W(4), .RDW_MODE(1), .CNT_W(2)) dut1 (
    .clk(clk), .rstn(rstn), .ra(ra), .re(re), .ore(ore), .dout(dout1), .dout_vld(vld1),
    .dout_collide(dc1), .wa(wa), .we(we), .wmask(wmask), .di(di), .collide_cnt(cnt1),
    .collide_cnt_clr(clr), .pwrbus_ram_pd(pwr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [5:0] a);
    return (int'(a) < DEPTH) ? mm[a] : 32'h0;
  endfunction

  // One clock: update the reference from this cycle's inputs, take the edge, check the counter.
  task automatic tick();
    bit col;
    col = re && we && (ra == wa) && (int'(ra) < DEPTH);
    if (!rstn) cnt_m = 0;
    else begin
      if (we && int'(wa) < DEPTH)
        for (int k = 0; k < 4; k++) if (wmask[k]) mm[wa][k*8 +: 8] = di[k*8 +: 8];
      if (clr) cnt_m = 0;
      else if (col && cnt_m < 3) cnt_m++;
    end
    pwr = $urandom;
    @(posedge clk);
    #1;
    chk("cnt_m0", 32'(cnt0), 32'(cnt_m));
    chk("cnt_m1", 32'(cnt1), 32'(cnt_m));
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] m);
    we = 1'b1; wa = 6'(a); di = d; wmask = m;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input int a);
    re = 1'b1; ra = 6'(a);
    tick();
    re = 1'b0; ore = 1'b1;
    tick();
    ore = 1'b0;
  endtask

  initial begin
    exp_t e, f;

    // Reset then idle
    tick(); tick();
    rstn = 1'b1;
    tick();
    chk("rst_dout0", dout0, 32'h0);
    chk("rst_dout1", dout1, 32'h0);
    chk("rst_vld", {30'b0, vld0, vld1}, 32'h0);
    chk("rst_col", {30'b0, dc0, dc1}, 32'h0);
    chk("rst_cnt", {28'b0, cnt0, cnt1}, 32'h0);

    for (int i = 0; i < DEPTH; i++) wr(i, $urandom, 4'hF);

    // Basic latency and hold
    wr(5, 32'hDEADBEEF, 4'hF);
    rd(5);
    chk("lat_dout0", dout0, 32'hDEADBEEF);
    chk("lat_dout1", dout1, 32'hDEADBEEF);
    chk("lat_vld", {30'b0, vld0, vld1}, 32'h3);
    wr(5, 32'h12345678, 4'hF);
    tick();
    chk("hold_dout0", dout0, 32'hDEADBEEF);
    chk("hold_dout1", dout1, 32'hDEADBEEF);
    chk("hold_vld", {30'b0, vld0, vld1}, 32'h3);

    // Masked write
    wr(7, 32'h11223344, 4'hF);
    wr(7, 32'hAABBCCDD, 4'b0101);
    rd(7);
    chk("mask_dout0", dout0, 32'h11BB33DD);
    chk("mask_dout1", dout1, 32'h11BB33DD);

    // Read-during-write collision
    wr(9, 32'h1, 4'hF);
    re = 1'b1; ra = 6'd9; we = 1'b1; wa = 6'd9; di = 32'h2; wmask = 4'hF;
    tick();
    re = 1'b0; we = 1'b0; ore = 1'b1;
    tick();
    ore = 1'b0;
    chk("rdw_dout0", dout0, 32'h2);
    chk("rdw_dout1", dout1, 32'h1);
    chk("rdw_col", {30'b0, dc0, dc1}, 32'h3);
    chk("rdw_cnt", 32'(cnt0), 32'h1);

    // Counter saturation and clear priority
    clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      re = 1'b1; we = 1'b1; ra = 6'd10; wa = 6'd10; di = $urandom; wmask = 4'hF;
      tick();
    end
    re = 1'b0; we = 1'b0;
    chk("sat_cnt", 32'(cnt0), 32'h3);
    re = 1'b1; we = 1'b1; clr = 1'b1;
    tick();
    re = 1'b0; we = 1'b0; clr = 1'b0;
    chk("clr_cnt", 32'(cnt1), 32'h0);

    // Out-of-range write/read, aliases unchanged
    wr(50, 32'hCAFEF00D, 4'hF);
    rd(50);
    chk("oor_dout0", dout0, 32'h0);
    chk("oor_dout1", dout1, 32'h0);
    rd(2);
    chk("alias2", dout0, mm[2]);
    rd(18);
    chk("alias18", dout1, mm[18]);

    // Reset between re and ore
    wr(0, 32'h0, 4'hF);
    re = 1'b1; ra = 6'd5; tick(); re = 1'b0;
    rstn = 1'b0; tick(); rstn = 1'b1;
    ore = 1'b1; tick(); ore = 1'b0;
    chk("mrst_dout0", dout0, 32'h0);
    chk("mrst_dout1", dout1, 32'h0);
    chk("mrst_vld", {30'b0, vld0, vld1}, 32'h0);

    // Random streaming with re and ore held high
    for (int i = 0; i < 300; i++) begin
      re = 1'b1; ore = 1'b1;
      ra = 6'($urandom_range(0, 55));
      we = 1'($urandom);
      wa = ($urandom_range(0, 3) == 0) ? ra : 6'($urandom_range(0, 55));
      wmask = 4'($urandom);
      di = $urandom;
      clr = ($urandom_range(0, 15) == 0);
      e.d1 = mread(ra);
      e.col = we && (ra == wa) && (int'(ra) < DEPTH);
      tick();
      e.d0 = mread(ra);
      q.push_back(e);
      if (q.size() == 2) begin
        f = q.pop_front();
        chk("rnd_dout0", dout0, f.d0);
        chk("rnd_dout1", dout1, f.d1);
        chk("rnd_vld", {30'b0, vld0, vld1}, 32'h3);
        chk("rnd_col0", 32'(dc0), 32'(f.col));
        chk("rnd_col1", 32'(dc1), 32'(f.col));
      end
    end
    re = 1'b0; ore = 1'b0; we = 1'b0; clr = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
